// File: rtl/pong_sound_arbiter.sv
// Speaker arbiter for Pong: latches one-cycle sound events, grants by fixed
// priority with preemption, and plays a per-source square-wave tone plus gap.
module pong_sound_arbiter #(
   parameter int TICK_DIV  = 25000,
   parameter int HALF3     = 125000,
   parameter int HALF2     = 28409,
   parameter int HALF1     = 14205,
   parameter int HALF0     = 6250,
   parameter int DUR3      = 500,
   parameter int DUR2      = 60,
   parameter int DUR1      = 30,
   parameter int DUR0      = 5,
   parameter int GAP_TICKS = 10
) (
   input  logic       clk25,
   input  logic       Reset,
   input  logic [3:0] req,
   output logic       Speaker,
   output logic       busy,
   output logic [1:0] active_src,
   output logic       grant
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXP = imax(imax(imax(TICK_DIV, GAP_TICKS), imax(imax(HALF3, HALF2), imax(HALF1, HALF0))),
                              imax(imax(DUR3, DUR2), imax(DUR1, DUR0)));
   localparam int CW = $clog2(MAXP) + 1;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t          state_reg, state_next;
   logic [3:0]      pend_reg, pend_next;
   logic [1:0]      src_reg, src_next;
   logic            spk_reg, spk_next;
   logic            grant_reg, grant_next;
   logic [CW-1:0]   half_reg, half_next;
   logic [CW-1:0]   dur_reg, dur_next;
   logic [CW-1:0]   presc_reg, presc_next;
   logic [CW-1:0]   gap_reg, gap_next;

   logic [3:0]      any_req;
   logic [3:0]      req_keep;
   logic [1:0]      win;
   logic            wrap;
   logic            start;

   function automatic logic [CW-1:0] half_of(input logic [1:0] s);
      case (s)
         2'd3:    return CW'(HALF3 - 1);
         2'd2:    return CW'(HALF2 - 1);
         2'd1:    return CW'(HALF1 - 1);
         default: return CW'(HALF0 - 1);
      endcase
   endfunction

   function automatic logic [CW-1:0] dur_of(input logic [1:0] s);
      case (s)
         2'd3:    return CW'(DUR3);
         2'd2:    return CW'(DUR2);
         2'd1:    return CW'(DUR1);
         default: return CW'(DUR0);
      endcase
   endfunction

   function automatic logic [1:0] top_of(input logic [3:0] v);
      if (v[3])      return 2'd3;
      else if (v[2]) return 2'd2;
      else if (v[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   always_comb begin
      any_req    = pend_reg | req;
      win        = top_of(any_req);
      wrap       = (presc_reg == CW'(TICK_DIV - 1));
      start      = 1'b0;
      state_next = state_reg;
      src_next   = src_reg;
      spk_next   = spk_reg;
      grant_next = 1'b0;
      half_next  = half_reg;
      dur_next   = dur_reg;
      presc_next = presc_reg;
      gap_next   = gap_reg;
      // A request from the playing source is a retrigger, never a pending event
      req_keep   = req;
      if (state_reg == PLAY)
         req_keep[src_reg] = 1'b0;
      pend_next  = pend_reg | req_keep;

      case (state_reg)
         IDLE: begin
            if (any_req != 4'd0)
               start = 1'b1;
         end
         PLAY: begin
            if (any_req != 4'd0 && win > src_reg) begin
               start = 1'b1;
            end else begin
               if (half_reg == '0) begin
                  spk_next  = ~spk_reg;
                  half_next = half_of(src_reg);
               end else begin
                  half_next = half_reg - CW'(1);
               end
               presc_next = wrap ? '0 : presc_reg + CW'(1);
               if (req[src_reg]) begin
                  dur_next = dur_of(src_reg);
               end else if (wrap) begin
                  if (dur_reg <= CW'(1)) begin
                     state_next = GAP;
                     spk_next   = 1'b0;
                     presc_next = '0;
                     gap_next   = CW'(GAP_TICKS);
                     dur_next   = '0;
                  end else begin
                     dur_next = dur_reg - CW'(1);
                  end
               end
            end
         end
         GAP: begin
            spk_next   = 1'b0;
            presc_next = wrap ? '0 : presc_reg + CW'(1);
            if (wrap) begin
               if (gap_reg <= CW'(1)) begin
                  state_next = IDLE;
                  gap_next   = '0;
               end else begin
                  gap_next = gap_reg - CW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (start) begin
         state_next     = PLAY;
         grant_next     = 1'b1;
         src_next       = win;
         spk_next       = 1'b1;
         half_next      = half_of(win);
         dur_next       = dur_of(win);
         presc_next     = '0;
         pend_next[win] = 1'b0;
      end
   end

   always_ff @(posedge clk25 or negedge Reset) begin
      if (!Reset) begin
         state_reg <= IDLE;
         pend_reg  <= '0;
         src_reg   <= '0;
         spk_reg   <= 1'b0;
         grant_reg <= 1'b0;
         half_reg  <= '0;
         dur_reg   <= '0;
         presc_reg <= '0;
         gap_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
         src_reg   <= src_next;
         spk_reg   <= spk_next;
         grant_reg <= grant_next;
         half_reg  <= half_next;
         dur_reg   <= dur_next;
         presc_reg <= presc_next;
         gap_reg   <= gap_next;
      end
   end

   assign Speaker    = spk_reg;
   assign busy       = (state_reg != IDLE);
   assign active_src = src_reg;
   assign grant      = grant_reg;

endmodule

// File: tb/tb_pong_sound_arbiter.sv
// Randomised scoreboard bench for pong_sound_arbiter using a timestamp-based
// model of grants, tone end times and square-wave phase.
module tb_pong_sound_arbiter;

   localparam int T  = 10;
   localparam int GT = 1;

   int half_m[4] = '{2, 4, 6, 8};
   int dur_m[4]  = '{2, 3, 4, 5};

   logic       clk25 = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] req   = 4'd0;
   logic       Speaker, busy, grant;
   logic [1:0] active_src;

   pong_sound_arbiter #(
      .TICK_DIV(T), .HALF3(8), .HALF2(6), .HALF1(4), .HALF0(2),
      .DUR3(5), .DUR2(4), .DUR1(3), .DUR0(2), .GAP_TICKS(GT)
   ) dut (
      .clk25(clk25), .Reset(Reset), .req(req), .Speaker(Speaker),
      .busy(busy), .active_src(active_src), .grant(grant)
   );

   always #5 clk25 = ~clk25;

   int cyc = 0;
   always @(posedge clk25) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { int cyc; int src; } exp_t;
   exp_t sb_q[$];

   // Model state: tone start, source, first GAP cycle, first IDLE cycle
   int         m_g, m_src, m_gs, m_idle;
   logic [3:0] m_pend;
   int         c_g, c_src, c_gs, c_idle;
   bit         in_reset = 1'b1;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
      end
   endtask

   function automatic int hi4(input logic [3:0] v);
      for (int i = 3; i >= 0; i--)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_init();
      m_g = 0; m_src = 0; m_gs = 0; m_idle = 0; m_pend = 4'd0;
      c_g = 0; c_src = 0; c_gs = 0; c_idle = 0;
      sb_q.delete();
   endtask

   task automatic step(input logic [3:0] r);
      int n, mode, w, w1;
      logic [3:0] s, rk;
      exp_t e;
      @(posedge clk25);
      #1;
      c_g = m_g; c_src = m_src; c_gs = m_gs; c_idle = m_idle;
      in_reset = 1'b0;
      req = r;
      n = cyc;
      mode = (n < m_gs) ? 1 : (n < m_idle) ? 2 : 0;
      s  = m_pend | r;
      rk = r;
      if (mode == 1) rk[m_src] = 1'b0;
      if (s != 4'd0 && (mode == 0 || (mode == 1 && hi4(s) > m_src))) begin
         w = hi4(s);
         m_pend = (m_pend | rk) & ~(4'd1 << w);
         m_g = n + 1; m_src = w;
         m_gs = m_g + dur_m[w] * T;
         m_idle = m_gs + GT * T;
         e.cyc = m_g; e.src = w;
         sb_q.push_back(e);
      end else begin
         m_pend = m_pend | rk;
         if (mode == 1 && r[m_src]) begin
            // Next tick boundary strictly after this cycle, then DUR-1 more ticks
            w1 = n + 1 + ((T - ((n + 1 - (m_g - 1)) % T)) % T);
            m_gs = w1 + (dur_m[m_src] - 1) * T + 1;
            m_idle = m_gs + GT * T;
         end
      end
   endtask

   task automatic idle(input int k);
      repeat (k) step(4'd0);
   endtask

   task automatic do_reset(input int hold);
      @(posedge clk25);
      #3;
      req = 4'd0;
      in_reset = 1'b1;
      Reset = 1'b0;
      #1;
      check("reset_speaker", Speaker, 0);
      check("reset_busy", busy, 0);
      check("reset_grant", grant, 0);
      check("reset_active_src", active_src, 0);
      repeat (hold) @(posedge clk25);
      #3;
      Reset = 1'b1;
      model_init();
   endtask

   always @(negedge clk25) begin
      int n;
      int exp_spk, exp_busy;
      if (!in_reset) begin
         n = cyc;
         exp_busy = (n < c_idle) ? 1 : 0;
         exp_spk  = (n >= c_g && n < c_gs) ? ((((n - c_g) / half_m[c_src]) % 2 == 0) ? 1 : 0) : 0;
         check("speaker", Speaker, exp_spk);
         check("busy", busy, exp_busy);
         check("active_src", active_src, c_src);
         while (sb_q.size() > 0 && sb_q[0].cyc < n) begin
            check("grant_missing", 0, 1);
            void'(sb_q.pop_front());
         end
         if (grant) begin
            if (sb_q.size() == 0 || sb_q[0].cyc != n) begin
               check("grant_unexpected", 1, 0);
            end else begin
               check("grant_src", active_src, sb_q[0].src);
               $display("grant cycle %0d src %0d", n, active_src);
               void'(sb_q.pop_front());
            end
         end else if (sb_q.size() > 0 && sb_q[0].cyc == n) begin
            check("grant_missing", 0, 1);
            void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_init();
      do_reset(2);
      // Reset mid-tone, then a wall request
      idle(3);
      step(4'b1000);
      idle(20);
      do_reset(2);
      idle(4);
      step(4'b0010);
      idle(60);
      // Simultaneous paddle and move
      step(4'b0101);
      idle(120);
      // Move preempted by miss
      step(4'b0001);
      idle(6);
      step(4'b1000);
      idle(80);
      // Wall retrigger
      step(4'b0010);
      idle(19);
      step(4'b0010);
      idle(60);
      // Repeated moves during a miss tone collapse to one
      step(4'b1000);
      idle(5);
      step(4'b0001);
      idle(9);
      step(4'b0001);
      idle(9);
      step(4'b0001);
      idle(100);
      // Reset during PLAY, then quiet
      step(4'b0100);
      idle(10);
      do_reset(3);
      idle(30);
      // Random sparse traffic
      repeat (800) begin
         if ($urandom_range(0, 11) == 0)
            step(4'($urandom_range(1, 15)));
         else
            step(4'd0);
      end
      idle(200);
      check("scoreboard_empty", sb_q.size(), 0);
      check("final_busy", busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_sound_arbiter.md
# pong_sound_arbiter

Shares the single Pong speaker between four sound-event requesters: miss, paddle hit, wall bounce and paddle movement. It latches one-cycle event requests, grants the speaker by fixed priority with preemption, and generates a square-wave tone of per-source pitch and duration. It sits between the game logic (ball collision and paddle encoder) and the `Speaker` pin, replacing direct single-source sound triggering.

## Interface
- `TICK_DIV`, 25000: clk25 cycles per duration tick (1 ms at 25 MHz).
- `HALF3`, 125000: miss tone half-period in cycles (100 Hz).
- `HALF2`, 28409: paddle tone half-period (440 Hz).
- `HALF1`, 14205: wall tone half-period (880 Hz).
- `HALF0`, 6250: move tone half-period (2 kHz).
- `DUR3`/`DUR2`/`DUR1`/`DUR0`, 500/60/30/5: tone durations in ticks.
- `GAP_TICKS`, 10: silent ticks after every tone.
- `clk25`  in  1  system clock, 25 MHz.
- `Reset`  in  1  reset, asynchronous, active-low.
- `req`  in  4  event requests, one cycle each: [3] miss, [2] paddle, [1] wall, [0] move.
- `Speaker`  out  1  square-wave output.
- `busy`  out  1  high in PLAY or GAP.
- `active_src`  out  2  index of the source currently or last granted.
- `grant`  out  1  one-cycle pulse on every grant, including preemption.

## Operation
- Pending register `pend[3:0]`: `pend[i]` is set on the cycle after `req[i]` is sampled high. It is cleared when source i is granted.
- Priority: 3 > 2 > 1 > 0. The winner is always the highest set bit of `pend | req`.
- States: IDLE, PLAY, GAP.
  - IDLE: if `pend | req` is nonzero, go to PLAY next cycle.
    - On entry to PLAY: pulse `grant`, load `active_src`, set `Speaker`=1, load the half-period counter with `HALF[src]-1`, load the duration counter with `DUR[src]`, zero the tick prescaler.
    - Clear `pend[src]`. A `req[src]` on the grant cycle is absorbed.
  - PLAY:
    - `Speaker` toggles each time the half-period counter reaches 0, then the counter reloads.
    - The prescaler wraps at `TICK_DIV-1`. Each wrap decrements the duration counter.
    - When the duration counter reaches 0 on a wrap, go to GAP and drive `Speaker`=0.
  - GAP: `Speaker`=0 for `GAP_TICKS` ticks, then go to IDLE.
- Preemption: in PLAY, if a request or pending bit has priority higher than `active_src`, regrant to it on the next cycle. This reloads all counters and pulses `grant`. The preempted source is dropped and not re-pended.
- Retrigger: `req[active_src]` during PLAY reloads the duration counter only. The phase is kept, and `pend` is not set.
- Lower-priority requests during PLAY or GAP are latched in `pend` and served after GAP. Multiple requests of the same source collapse to one.
- Counter widths are `$clog2` of the largest parameter plus 1. All arithmetic is unsigned with no wrap.

## Timing
- Reset values: `Speaker`=0, `busy`=0, `active_src`=0, `grant`=0, `pend`=0, state IDLE, all counters 0.
- Reset asserted mid-tone silences `Speaker` immediately (asynchronous).
- Latency: `req` high at cycle N in IDLE gives `grant`=1, `Speaker`=1 and `busy`=1 at cycle N+1.
- Tone duration is `DUR*TICK_DIV` cycles, ±1 cycle. The gap is `GAP_TICKS*TICK_DIV` cycles.
- From the end of GAP to the next grant of a pending request: 1 IDLE cycle.
- Simultaneous requests: the highest index wins. The others stay pending and are served in priority order.
- Preemption takes effect 1 cycle after the higher request is sampled.

## Test plan
Parameters for all scenarios: `TICK_DIV`=10, `HALF3..0`=8/6/4/2, `DUR3..0`=5/4/3/2, `GAP_TICKS`=1.

1. Reset mid-tone, then `req`=4'b0010 at cycle 5 → `grant` at 6, `active_src`=1, `Speaker` toggles every 4 cycles for 30 cycles, then low, `busy` falls after the 10-cycle gap.
2. `req`=4'b0101 in one cycle → source 2 plays 40 cycles, gap 10, 1 IDLE cycle, then source 0 plays 20 cycles.
3. `req[0]` at 5, `req[3]` at 12 → `grant` at 13 with `active_src`=3, source 0 never resumes, the miss tone lasts 50 cycles.
4. `req[1]` at 5, repeated at 25 → the tone ends 30 cycles after cycle 25 with no phase glitch at the retrigger.
5. `req[0]` pulsed 3 times during a miss tone → exactly one move tone after the gap.
6. `Reset` low during PLAY → all outputs 0 the same cycle. After release with no requests, the block stays in IDLE.
